// File: rtl/traffic_light_ctrl_n.sv
// N-approach round-robin traffic-light controller with demand latching and green extension.
// Optional emergency preemption is compiled in when TL_EMERG_PREEMPT_EN is defined.
module traffic_light_ctrl_n #(
    parameter int N_APPR    = 2,
    parameter int CNT_W     = 8,
    parameter int T_GREEN   = 4,
    parameter int T_MAX_EXT = 4,
    parameter int T_YELLOW  = 2,
    parameter int T_ALLRED  = 1,
    localparam int PW = (N_APPR > 1) ? $clog2(N_APPR) : 1
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [N_APPR-1:0]   SENS,
`ifdef TL_EMERG_PREEMPT_EN
    input  logic                EMERG,
    input  logic [PW-1:0]       EMERG_ID,
`endif
    output logic [2*N_APPR-1:0] LIGHT,
    output logic [2*N_APPR-1:0] PED,
    output logic [PW-1:0]       PHASE
);

    typedef enum logic [1:0] {
        ST_ALLRED = 2'd0,
        ST_GREEN  = 2'd1,
        ST_YELLOW = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      timer_q, timer_d;
    logic [CNT_W-1:0]      ext_q, ext_d;
    logic [PW-1:0]         phase_q, phase_d;
    logic [N_APPR-1:0]     demand_q, demand_d;
    logic [2*N_APPR-1:0]   light_q, light_d;
    logic [2*N_APPR-1:0]   ped_q, ped_d;

    logic                  ext_inc;
    logic                  others_waiting;
    logic                  emerg_ok;
    logic [PW-1:0]         emerg_id;

    // First approach with latched demand after cur (wrapping, cur itself last); cur+1 if none.
    function automatic logic [PW-1:0] rr_pick(input logic [PW-1:0] cur,
                                              input logic [N_APPR-1:0] dem);
        logic [PW-1:0] pick;
        logic          found;
        int            idx;
        idx   = (int'(cur) + 1) % N_APPR;
        pick  = PW'(idx);
        found = 1'b0;
        for (int k = 1; k <= N_APPR; k++) begin
            idx = (int'(cur) + k) % N_APPR;
            if (!found && dem[idx]) begin
                pick  = PW'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

`ifdef TL_EMERG_PREEMPT_EN
    assign emerg_ok = EMERG && (int'(EMERG_ID) < N_APPR);
    assign emerg_id = EMERG_ID;
`else
    assign emerg_ok = 1'b0;
    assign emerg_id = '0;
`endif

    always_comb begin
        state_d        = state_q;
        phase_d        = phase_q;
        ext_inc        = 1'b0;
        others_waiting = 1'b0;
        for (int i = 0; i < N_APPR; i++) begin
            if (demand_q[i] && (phase_q != PW'(i))) begin
                others_waiting = 1'b1;
            end
        end

        case (state_q)
            ST_ALLRED: begin
                if (int'(timer_q) >= T_ALLRED - 1) begin
                    state_d = ST_GREEN;
                    phase_d = emerg_ok ? emerg_id : rr_pick(phase_q, demand_q);
                end
            end
            ST_GREEN: begin
                if (emerg_ok && (phase_q != emerg_id)) begin
                    state_d = ST_YELLOW;
                end else if (emerg_ok) begin
                    state_d = ST_GREEN;
                end else if (int'(timer_q) >= T_GREEN - 1) begin
                    if (SENS[phase_q] && !others_waiting && (int'(ext_q) < T_MAX_EXT)) begin
                        ext_inc = 1'b1;
                    end else begin
                        state_d = ST_YELLOW;
                    end
                end
            end
            ST_YELLOW: begin
                if (int'(timer_q) >= T_YELLOW - 1) begin
                    state_d = ST_ALLRED;
                end
            end
            default: begin
                state_d = ST_ALLRED;
            end
        endcase

        // Both counters restart on every state change and saturate instead of wrapping.
        if (state_d != state_q) begin
            timer_d = '0;
            ext_d   = '0;
        end else begin
            timer_d = (&timer_q) ? timer_q : timer_q + 1'b1;
            ext_d   = (ext_inc && !(&ext_q)) ? ext_q + 1'b1 : ext_q;
        end

        // Demand for an approach is cleared as it enters GREEN, which beats a same-cycle set.
        for (int i = 0; i < N_APPR; i++) begin
            demand_d[i] = (demand_q[i] || (SENS[i] && !((state_q == ST_GREEN) && (phase_q == PW'(i)))))
                          && !((state_q == ST_ALLRED) && (state_d == ST_GREEN) && (phase_d == PW'(i)));
        end

        light_d = '0;
        ped_d   = '0;
        for (int i = 0; i < N_APPR; i++) begin
            if (phase_d == PW'(i)) begin
                if (state_d == ST_GREEN) begin
                    light_d[2*i +: 2] = 2'b10;
                    ped_d[2*i +: 2]   = 2'b10;
                end else if (state_d == ST_YELLOW) begin
                    light_d[2*i +: 2] = 2'b01;
                    ped_d[2*i +: 2]   = 2'b01;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= ST_ALLRED;
            timer_q  <= '0;
            ext_q    <= '0;
            phase_q  <= PW'(N_APPR - 1);
            demand_q <= '0;
            light_q  <= '0;
            ped_q    <= '0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            ext_q    <= ext_d;
            phase_q  <= phase_d;
            demand_q <= demand_d;
            light_q  <= light_d;
            ped_q    <= ped_d;
        end
    end

    assign LIGHT = light_q;
    assign PED   = ped_q;
    assign PHASE = phase_q;

endmodule

// File: tb/tb_traffic_light_ctrl_n.sv
// Scoreboard bench for traffic_light_ctrl_n (N_APPR=2, default timing): a behavioural
// model predicts every cycle's outputs into a queue that an independent monitor drains.
module tb_traffic_light_ctrl_n;

    localparam int N  = 2;
    localparam int PW = 1;
    localparam int TG = 4;
    localparam int TX = 4;
    localparam int TY = 2;
    localparam int TR = 1;

    localparam int M_RED    = 0;
    localparam int M_GREEN  = 1;
    localparam int M_YELLOW = 2;

    typedef struct packed {
        logic [2*N-1:0] light;
        logic [2*N-1:0] ped;
        logic [PW-1:0]  phase;
    } exp_t;

    logic           CLK = 1'b0;
    logic           RST;
    logic [N-1:0]   SENS;
    logic [2*N-1:0] LIGHT;
    logic [2*N-1:0] PED;
    logic [PW-1:0]  PHASE;

    exp_t sb_q[$];
    int   compared   = 0;
    int   mismatched = 0;
    bit   mon_en     = 1'b0;
    int   cycle_no   = 0;

    int           m_stage;
    int           m_left;
    int           m_elapsed;
    int           m_phase;
    logic [N-1:0] m_dem;

    traffic_light_ctrl_n #(
        .N_APPR(N), .CNT_W(8), .T_GREEN(TG), .T_MAX_EXT(TX), .T_YELLOW(TY), .T_ALLRED(TR)
    ) dut (
        .CLK(CLK), .RST(RST), .SENS(SENS), .LIGHT(LIGHT), .PED(PED), .PHASE(PHASE)
    );

    always #5 CLK = ~CLK;

    function automatic int nextServed(input int cur, input logic [N-1:0] dem);
        for (int k = 1; k <= N; k++) begin
            if (dem[(cur + k) % N]) return (cur + k) % N;
        end
        return (cur + 1) % N;
    endfunction

    // One clock edge of the reference intersection, given the inputs seen at that edge.
    task automatic modelStep(input logic [N-1:0] s, input logic r, output exp_t e);
        logic [N-1:0] nd;
        logic [N-1:0] old;
        logic [N-1:0] others;
        if (!r) begin
            m_stage   = M_RED;
            m_left    = TR;
            m_phase   = N - 1;
            m_dem     = '0;
            m_elapsed = 0;
        end else begin
            old = m_dem;
            for (int i = 0; i < N; i++) begin
                nd[i] = m_dem[i] | (s[i] & !((m_stage == M_GREEN) && (m_phase == i)));
            end
            case (m_stage)
                M_RED: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_phase     = nextServed(m_phase, old);
                        m_stage     = M_GREEN;
                        m_elapsed   = 0;
                        nd[m_phase] = 1'b0;
                    end
                end
                M_GREEN: begin
                    m_elapsed++;
                    others = old;
                    others[m_phase] = 1'b0;
                    if (m_elapsed >= TG &&
                        !(s[m_phase] && others == '0 && m_elapsed < TG + TX)) begin
                        m_stage = M_YELLOW;
                        m_left  = TY;
                    end
                end
                default: begin
                    m_left--;
                    if (m_left == 0) begin
                        m_stage = M_RED;
                        m_left  = TR;
                    end
                end
            endcase
            m_dem = nd;
        end
        e.light = '0;
        e.ped   = '0;
        e.phase = PW'(m_phase);
        if (m_stage == M_GREEN) begin
            e.light[2*m_phase +: 2] = 2'b10;
            e.ped[2*m_phase +: 2]   = 2'b10;
        end else if (m_stage == M_YELLOW) begin
            e.light[2*m_phase +: 2] = 2'b01;
            e.ped[2*m_phase +: 2]   = 2'b01;
        end
    endtask

    task automatic applyStimulus(input logic [N-1:0] s, input logic r);
        exp_t e;
        @(negedge CLK);
        SENS = s;
        RST  = r;
        modelStep(s, r, e);
        sb_q.push_back(e);
        mon_en = 1'b1;
    endtask

    task automatic checkOutput();
        exp_t e;
        cycle_no++;
        compared++;
        if (sb_q.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL scoreboard_empty cycle %0d: no prediction queued", cycle_no);
        end else begin
            e = sb_q.pop_front();
            if (LIGHT !== e.light || PED !== e.ped || PHASE !== e.phase) begin
                mismatched++;
                $display("[TB] FAIL outputs cycle %0d: got LIGHT=%b PED=%b PHASE=%0d, expected LIGHT=%b PED=%b PHASE=%0d",
                         cycle_no, LIGHT, PED, PHASE, e.light, e.ped, e.phase);
            end
        end
    endtask

    task automatic timeoutFail(input string what);
        compared++;
        mismatched++;
        $display("[TB] FAIL %s: condition not reached within cycle budget", what);
    endtask

    initial begin
        forever begin
            @(posedge CLK);
            #2;
            if (mon_en) checkOutput();
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        RST  = 1'b0;
        SENS = '0;
        repeat (3) applyStimulus(2'b00, 1'b0);
        repeat (30) applyStimulus(2'b00, 1'b1);
        repeat (30) applyStimulus(2'b11, 1'b1);
        repeat (30) applyStimulus(2'b01, 1'b1);

        // Approach 0 in its extension, then a one-cycle request from approach 1.
        for (int c = 0; c < 40 && !(m_stage == M_GREEN && m_phase == 0 && m_elapsed == 5); c++)
            applyStimulus(2'b01, 1'b1);
        if (!(m_stage == M_GREEN && m_phase == 0 && m_elapsed == 5)) timeoutFail("reach_a_extension");
        applyStimulus(2'b11, 1'b1);
        repeat (15) applyStimulus(2'b01, 1'b1);

        // Asynchronous reset in the second cycle of approach 1's green.
        for (int c = 0; c < 40 && !(m_stage == M_GREEN && m_phase == 1 && m_elapsed == 1); c++)
            applyStimulus(2'b10, 1'b1);
        if (!(m_stage == M_GREEN && m_phase == 1 && m_elapsed == 1)) timeoutFail("reach_b_green");
        @(posedge CLK);
        #3;
        RST = 1'b0;
        #1;
        compared++;
        if (LIGHT !== 4'b0000 || PED !== 4'b0000 || PHASE !== PW'(N - 1)) begin
            mismatched++;
            $display("[TB] FAIL async_reset: got LIGHT=%b PED=%b PHASE=%0d, expected LIGHT=0000 PED=0000 PHASE=%0d",
                     LIGHT, PED, PHASE, N - 1);
        end
        repeat (2) applyStimulus(2'b10, 1'b0);
        repeat (20) applyStimulus(2'b10, 1'b1);

        for (int c = 0; c < 400; c++) begin
            logic [N-1:0] s;
            logic         r;
            s = '0;
            for (int i = 0; i < N; i++) s[i] = ($urandom_range(0, 3) == 0);
            if (c % 100 >= 50) s = ($urandom_range(0, 5) == 0) ? 2'b11 : s | 2'b01;
            r = ($urandom_range(0, 149) != 0);
            applyStimulus(s, r);
        end
        repeat (10) applyStimulus(2'b00, 1'b1);

        @(posedge CLK);
        #4;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
